led_bank_scheduler: RTL
=======================

# led_bank_scheduler

Time-shares the 16-LED bank between up to NREQ pattern sources with round-robin arbitration and a tick-based time slot. It contains its own free-running tick generator, so pattern sources can advance on the `tick` enable instead of a derived slow clock. It sits between the pattern generators and the top-level `LED` output. All logic runs on the board clock `clk`.

## Interface
- `NREQ`, default 4: number of requesters, from 2 to 8. `OW = $clog2(NREQ)`.
- `TICK_DIV`, default 50_000_000: `clk` cycles per tick. Minimum 2. The default gives 2 Hz at 100 MHz.
- `SLOT_TICKS`, default 8: ticks per grant slot. Minimum 1.

Ports:
- `clk`, in, 1: 100 MHz board clock.
- `rst`, in, 1: reset, synchronous, active-high.
- `req`, in, NREQ: request level. Requester i holds `req[i]` high for as long as it wants the bank.
- `done`, in, NREQ: one-cycle early-release pulse. `done[i]` is ignored unless i is the current owner.
- `pattern`, in, NREQ*16: requester i drives bits [16i+15:16i].
- `tick`, out, 1: one-cycle pulse every TICK_DIV cycles.
- `grant`, out, NREQ: one-hot grant, or all zero.
- `owner`, out, OW: index of the current or last owner.
- `busy`, out, 1: high while in the OWN state.
- `LED`, out, 16: registered bank output.

## Operation
**Tick generator**
- `tcnt` runs 0..TICK_DIV-1 and then wraps to 0.
- `tick` = 1 during the cycle in which `tcnt == TICK_DIV-1`.
- The generator is free-running and independent of the FSM.

**FSM states: IDLE, OWN, GAP**

IDLE
- Outputs: `grant` = 0, `LED` = 0, `busy` = 0.
- If any `req` is high, the winner is the first set bit searched from `rr+1` upward, modulo NREQ.
- On that edge: `grant` becomes one-hot for the winner, `owner` = winner, `rr` = winner, `slot_cnt` = 0, next state OWN.

OWN
- Each cycle: `LED` <= `pattern[owner]`.
- On each `tick`, `slot_cnt` increments, saturating at SLOT_TICKS.
- Release goes to GAP when any of the following is true:
  - (a) `req[owner]` = 0.
  - (b) `done[owner]` = 1.
  - (c) `tick` and `slot_cnt == SLOT_TICKS-1` and some other `req[j]` is high (j ≠ owner).
- If (c) expires with no other requester pending, the owner keeps the grant, `slot_cnt` is set to 0, and there is no gap.
- If several release causes occur in the same cycle, there is a single release.

GAP
- Lasts exactly one cycle: `grant` = 0, `LED` = 0, `busy` = 0.
- Next cycle it arbitrates exactly as in IDLE. The former owner is lowest priority because `rr` = owner.
- If no `req` is high, it returns to IDLE.

**Reset**
- `rst` high at any edge, including mid-slot or in GAP, gives on that edge:
  - state IDLE, `grant` = 0, `owner` = 0, `busy` = 0, `LED` = 0.
  - `tcnt` = 0, `slot_cnt` = 0.
  - `rr` = NREQ-1, so requester 0 wins first.
- `rst` has priority over every other input.

**Widths**
- `slot_cnt` is `$clog2(SLOT_TICKS+1)` bits.
- `tcnt` is `$clog2(TICK_DIV)` bits.
- Round-robin arithmetic is modulo NREQ, for non-power-of-2 NREQ as well.

## Timing
- Grant latency: `req` sampled at edge N, `grant` asserted after edge N. From an idle bank this is 1 cycle.
- `LED` follows `pattern[owner]` with 1 cycle of latency, starting the first cycle after the grant rises.
- Handover: the old grant drops at edge N, GAP holds for one cycle, and the new grant rises at edge N+1. Minimum handover is 2 edges, and `LED` = 0 for one cycle.
- Slot length: a slot is SLOT_TICKS ticks measured from the first tick after the grant. The first partial tick period counts as part of the slot, which is therefore between (SLOT_TICKS-1)·TICK_DIV+1 and SLOT_TICKS·TICK_DIV cycles.
- `tick` period is exactly TICK_DIV cycles. The first `tick` after reset comes TICK_DIV cycles after reset deassertion.

## Configuration
- Macro: `LED_SCHED_PREEMPT_EN`.
- Defined: requester 0 is high-priority. While another requester owns the bank and `req[0]` = 1, the owner is released on the next `tick` regardless of `slot_cnt`. The GAP that follows grants requester 0 unconditionally.
- Not defined: pure round-robin with no preemption. `req[0]` waits for normal slot expiry or release.

## Test plan
Bench parameters: NREQ = 4, TICK_DIV = 4, SLOT_TICKS = 2.
1. Reset, then `req` = 4'b0100 with `pattern[2]` = 16'hA5A5 → `grant` = 4'b0100 one cycle later, `LED` = 16'hA5A5 one cycle after that, `busy` = 1.
2. `req` = 4'b1111 held → grants rotate 0,1,2,3,0. Each holds until the 2nd tick after its grant. Each handover shows 1 cycle with `grant` = 0 and `LED` = 0.
3. Sole requester 1 held for 20 cycles → `grant` stays 4'b0010 continuously with no gap, and `slot_cnt` rolls to 0 at each expiry.
4. Owner 2 pulses `done[2]` while `done[3]` also pulses (non-owner) → one release. `done[3]` is ignored. Next grant goes to the requester at or after 3 that has `req` high.
5. `rst` asserted mid-slot while owner = 3 → next edge gives `grant` = 0, `LED` = 0, `tick` = 0 for the following 3 cycles. With `req` = 4'b1001 after reset, requester 0 wins first.
6. With `LED_SCHED_PREEMPT_EN` defined: owner 2, `req[0]` rises → grant 2 drops at the next `tick`, and `grant` = 4'b0001 two edges later. Without the macro, requester 0 waits for slot expiry.

Source files
------------

// File: rtl/led_bank_scheduler.sv
// Round-robin time-slot scheduler for the 16-LED bank, with its own tick.
// Optional macro LED_SCHED_PREEMPT_EN makes requester 0 preempt on a tick.
module led_bank_scheduler #(
  parameter int NREQ       = 4,
  parameter int TICK_DIV   = 50_000_000,
  parameter int SLOT_TICKS = 8,
  localparam int OW        = $clog2(NREQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ-1:0]    done,
  input  logic [NREQ*16-1:0] pattern,
  output logic               tick,
  output logic [NREQ-1:0]    grant,
  output logic [OW-1:0]      owner,
  output logic               busy,
  output logic [15:0]        LED
);

  localparam int TW = $clog2(TICK_DIV);
  localparam int SW = $clog2(SLOT_TICKS + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_OWN,
    S_GAP
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [TW-1:0]   r_tcnt;
  logic [SW-1:0]   r_slot;
  logic [OW-1:0]   r_rr;
  logic [OW-1:0]   r_owner;
  logic [NREQ-1:0] r_grant;
  logic [15:0]     r_led;

  logic            w_tick;
  logic            w_found;
  logic [OW-1:0]   w_win;
  logic [15:0]     w_pat;
  logic [NREQ-1:0] w_ownhot;
  logic            w_others;
  logic            w_expire;
  logic            w_preempt;
  logic            w_rel;

`ifdef LED_SCHED_PREEMPT_EN
  logic            r_pre;
`endif

  assign w_tick = (r_tcnt == TW'(TICK_DIV - 1));

  // Free-running tick divider, independent of the scheduler state
  always_ff @(posedge clk) begin
    if (rst) r_tcnt <= '0;
    else if (w_tick) r_tcnt <= '0;
    else r_tcnt <= r_tcnt + TW'(1);
  end

  // Round-robin search starting just after the last winner
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!w_found && req[(int'(r_rr) + k) % NREQ]) begin
        w_found = 1'b1;
        w_win   = OW'((int'(r_rr) + k) % NREQ);
      end
    end
`ifdef LED_SCHED_PREEMPT_EN
    if (r_pre && req[0]) begin
      w_found = 1'b1;
      w_win   = '0;
    end
`endif
  end

  // Pattern mux for the current owner
  always_comb begin
    w_pat = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (r_owner == OW'(i)) w_pat = pattern[i*16 +: 16];
    end
  end

  assign w_ownhot = NREQ'(1) << r_owner;
  assign w_others = |(req & ~w_ownhot);
  assign w_expire = w_tick && (r_slot == SW'(SLOT_TICKS - 1));

`ifdef LED_SCHED_PREEMPT_EN
  assign w_preempt = w_tick && req[0] && (r_owner != '0);
`else
  assign w_preempt = 1'b0;
`endif

  assign w_rel = !req[r_owner] || done[r_owner] ||
                 (w_expire && w_others) || w_preempt;

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else r_state <= w_next;
  end

  // Next-state: arbitrate when not owning, release on any cause
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE, S_GAP: w_next = w_found ? S_OWN : S_IDLE;
      S_OWN:         if (w_rel) w_next = S_GAP;
      default:       w_next = S_IDLE;
    endcase
  end

  // Grant, owner, slot counter and registered LED bank
  always_ff @(posedge clk) begin
    if (rst) begin
      r_owner <= '0;
      r_rr    <= OW'(NREQ - 1);
      r_slot  <= '0;
      r_grant <= '0;
      r_led   <= '0;
`ifdef LED_SCHED_PREEMPT_EN
      r_pre   <= 1'b0;
`endif
    end else if (r_state != S_OWN) begin
      r_led <= '0;
      if (w_found) begin
        r_owner <= w_win;
        r_rr    <= w_win;
        r_slot  <= '0;
        r_grant <= NREQ'(1) << w_win;
`ifdef LED_SCHED_PREEMPT_EN
        r_pre   <= 1'b0;
`endif
      end
    end else if (w_rel) begin
      r_grant <= '0;
      r_led   <= '0;
`ifdef LED_SCHED_PREEMPT_EN
      r_pre   <= w_preempt;
`endif
    end else begin
      r_led <= w_pat;
      if (w_tick) begin
        if (w_expire) r_slot <= '0;
        else if (r_slot != SW'(SLOT_TICKS)) r_slot <= r_slot + SW'(1);
      end
    end
  end

  assign tick  = w_tick;
  assign grant = r_grant;
  assign owner = r_owner;
  assign busy  = (r_state == S_OWN);
  assign LED   = r_led;

endmodule
